mem_access_ctrl: RTL and testbench

Data-memory access controller between the execute stage and the load-extension unit. It turns a load/store request into one transaction on the data bus using a valid/ready handshake, and generates byte strobes and lane-aligned write data. It stalls the pipeline until the bus completes. For loads it registers the raw 32-bit bus word and the byte offset, and presents them as the data input and word select of the load-extension stage.

---
 rtl/mem_access_pkg.sv | 28 ++
 rtl/mem_access_ctrl_if.sv | 25 ++
 rtl/mem_strb_gen.sv | 35 +++
 rtl/mem_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_access_pkg;

    localparam int unsigned ADDR_W              = 32;
    localparam int unsigned DATA_W              = 32;
    localparam int unsigned STRB_W              = DATA_W / 8;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Latched request payload presented on the data bus
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-bus valid/ready handshake between the access controller and memory.
interface mem_access_ctrl_if
    import mem_access_pkg::*;
();

    logic              bus_valid;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [STRB_W-1:0] bus_wstrb;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/mem_strb_gen.sv
// Maps access size and byte offset to byte strobes, lane-aligned store data
// and a misalignment flag. Purely combinational.
module mem_strb_gen
    import mem_access_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic              misalign_c
);

    // Size code 11 falls into the word branch
    always_comb begin
        wstrb_c    = '1;
        misalign_c = 1'b0;
        case (size)
            MEM_SIZE_B: begin
                wstrb_c = STRB_W'(4'b0001 << offset);
            end
            MEM_SIZE_H: begin
                wstrb_c    = STRB_W'(4'b0011 << offset);
                misalign_c = (offset == 2'd3);
            end
            default: begin
                wstrb_c    = '1;
                misalign_c = (offset != 2'd0);
            end
        endcase
    end

    assign wdata_c = wdata << {offset, 3'b000};

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: one valid/ready bus transaction per load/store,
// pipeline stall until completion. Build macro MISALIGN_TRAP_EN enables the misalignment trap.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata_raw,
    output logic [1:0]        word_sel,
    output logic              bus_err,
    output logic              misalign,
    mem_access_ctrl_if.master bus
);

    localparam int unsigned CNT_NEED = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_W    = (CNT_NEED > 8) ? CNT_NEED : 8;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e            state;
    state_e            next_state;
    logic [CNT_W-1:0]  cnt;
    bus_req_t          req_q;
    logic [1:0]        off_q;
    logic              bus_valid_q;
    logic              misalign_q;

    logic [STRB_W-1:0] wstrb_c;
    logic [DATA_W-1:0] wdata_c;
    logic              misalign_c;
    logic              trap_c;
    logic              timeout_c;

    logic              bus_valid_d;
    logic              done_d;
    logic              bus_err_d;
    logic              misalign_d;
    logic              req_ld;
    logic              rd_cap;
    logic              rd_clr;

    mem_strb_gen u_strb_gen (
        .size       (mem_size),
        .offset     (mem_addr[1:0]),
        .wdata      (mem_wdata),
        .wstrb_c    (wstrb_c),
        .wdata_c    (wdata_c),
        .misalign_c (misalign_c)
    );

    assign trap_c    = TRAP_EN && misalign_c;
    assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) state <= ST_IDLE;
        else           state <= next_state;
    end

    // Next-state logic; bus progress takes priority over the timeout
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (mem_req) next_state = trap_c ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                if (bus.bus_ready)  next_state = (req_q.we || bus.bus_rvalid) ? ST_DONE : ST_WAIT;
                else if (timeout_c) next_state = ST_DONE;
            end
            ST_WAIT: begin
                if (bus.bus_rvalid || timeout_c) next_state = ST_DONE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath load enables
    always_comb begin
        bus_valid_d = (next_state == ST_REQ);
        done_d      = (next_state == ST_DONE);
        bus_err_d   = 1'b0;
        misalign_d  = 1'b0;
        req_ld      = 1'b0;
        rd_cap      = 1'b0;
        rd_clr      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ld     = mem_req && !trap_c;
                misalign_d = mem_req && trap_c;
            end
            ST_REQ: begin
                if (bus.bus_ready) begin
                    rd_cap = !req_q.we && bus.bus_rvalid;
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    rd_clr    = !req_q.we;
                end
            end
            ST_WAIT: begin
                if (bus.bus_rvalid) begin
                    rd_cap = 1'b1;
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    rd_clr    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output, request and load-data registers
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            bus_valid_q <= 1'b0;
            done        <= 1'b0;
            bus_err     <= 1'b0;
            misalign_q  <= 1'b0;
            cnt         <= '0;
            req_q       <= '0;
            off_q       <= 2'b00;
            rdata_raw   <= '0;
            word_sel    <= 2'b00;
        end else begin
            bus_valid_q <= bus_valid_d;
            done        <= done_d;
            bus_err     <= bus_err_d;
            misalign_q  <= misalign_d;

            if ((next_state == ST_REQ  && state != ST_REQ) ||
                (next_state == ST_WAIT && state != ST_WAIT)) begin
                cnt <= '0;
            end else if (state == ST_REQ || state == ST_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (req_ld) begin
                req_q <= '{we:    mem_we,
                           addr:  {mem_addr[ADDR_W-1:2], 2'b00},
                           wstrb: wstrb_c,
                           wdata: wdata_c};
                off_q <= mem_addr[1:0];
            end

            if (rd_cap) begin
                rdata_raw <= bus.bus_rdata;
                word_sel  <= off_q;
            end else if (rd_clr) begin
                rdata_raw <= '0;
                word_sel  <= off_q;
            end
        end
    end

    assign stall = (state == ST_IDLE && mem_req) || (state == ST_REQ) || (state == ST_WAIT);
    assign misalign = misalign_q;

    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_we    = req_q.we;
    assign bus.bus_addr  = req_q.addr;
    assign bus.bus_wstrb = req_q.wstrb;
    assign bus.bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a completion scoreboard.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    localparam int unsigned TO = 255;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata_raw;
    logic [1:0]  word_sel;
    logic        bus_err;
    logic        misalign;

    mem_access_ctrl_if bus_if ();

    mem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .stall     (stall),
        .done      (done),
        .rdata_raw (rdata_raw),
        .word_sel  (word_sel),
        .bus_err   (bus_err),
        .misalign  (misalign),
        .bus       (bus_if)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        err;
        logic        mis;
        logic [31:0] rdata;
        logic [1:0]  wsel;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] m_rdata;
    logic [1:0]  m_wsel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        int ai;
        ai = int'(a);
        for (int i = 0; i < 4; i++) begin
            case (size)
                2'b00:   s[i] = (i == ai);
                2'b01:   s[i] = (i == ai) || (i == ai + 1);
                default: s[i] = 1'b1;
            endcase
        end
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] a);
        logic [31:0] r;
        int ai;
        ai = int'(a);
        r = 32'h0;
        for (int i = 0; i < 4; i++)
            if (i >= ai) r[8*i +: 8] = wd[8*(i-ai) +: 8];
        return r;
    endfunction

    function automatic bit is_mis(input logic [1:0] size, input logic [1:0] a);
        return (size == 2'b01 && a == 2'd3) || (size[1] && a != 2'd0);
    endfunction

    // One access from IDLE; rdy_wait = REQ cycles before ready, rv_wait = WAIT cycle carrying rvalid (0: with ready)
    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int rdy_wait, input int rv_wait, input logic [31:0] rdata);
        exp_t e;
        exp_t got;
        int   cyc;
        int   vcnt;
        int   wcnt;
        int   exp_vcnt;
        bit   trap;
        bit   tmo;
        bit   ready_given;
        bit   done_seen;
        bit   stall_ok;

        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = is_mis(size, addr[1:0]);
`endif
        tmo = !trap && (rdy_wait >= int'(TO));
        if (!we && !trap) begin
            m_rdata = tmo ? 32'h0 : rdata;
            m_wsel  = addr[1:0];
        end
        e.err   = tmo;
        e.mis   = trap;
        e.rdata = m_rdata;
        e.wsel  = m_wsel;
        if (trap)     e.lat = 1;
        else if (tmo) e.lat = 1 + int'(TO);
        else          e.lat = 2 + rdy_wait + (we ? 0 : rv_wait);
        exp_vcnt = trap ? 0 : (tmo ? int'(TO) : rdy_wait + 1);
        sb.push_back(e);

        mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
        #1;
        chk({tag, "/stall_idle"}, 32'(stall), 32'd1);

        cyc = 0; vcnt = 0; wcnt = 0; ready_given = 1'b0; done_seen = 1'b0; stall_ok = 1'b1;
        while (!done_seen && cyc < 600) begin
            tick();
            cyc++;
            bus_if.bus_ready  = 1'b0;
            bus_if.bus_rvalid = 1'b0;
            bus_if.bus_rdata  = $urandom();
            if (done) begin
                done_seen = 1'b1;
            end else begin
                if (!stall) stall_ok = 1'b0;
                if (bus_if.bus_valid) begin
                    if (vcnt == 0) begin
                        chk({tag, "/bus_addr"},  bus_if.bus_addr, {addr[31:2], 2'b00});
                        chk({tag, "/bus_we"},    32'(bus_if.bus_we), 32'(we));
                        chk({tag, "/bus_wstrb"}, 32'(bus_if.bus_wstrb), 32'(model_strb(size, addr[1:0])));
                        if (we) chk({tag, "/bus_wdata"}, bus_if.bus_wdata, model_wdata(wdata, addr[1:0]));
                    end
                    vcnt++;
                    if (vcnt > rdy_wait) begin
                        bus_if.bus_ready = 1'b1;
                        ready_given      = 1'b1;
                        if (!we && rv_wait == 0) begin
                            bus_if.bus_rvalid = 1'b1;
                            bus_if.bus_rdata  = rdata;
                        end
                    end
                end else if (ready_given) begin
                    wcnt++;
                    if (wcnt >= rv_wait) begin
                        bus_if.bus_rvalid = 1'b1;
                        bus_if.bus_rdata  = rdata;
                    end
                end
            end
        end

        got = sb.pop_front();
        chk({tag, "/done_seen"}, 32'(done_seen), 32'd1);
        if (done_seen) begin
            chk({tag, "/latency"},   32'(cyc), 32'(got.lat));
            chk({tag, "/valid_cyc"}, 32'(vcnt), 32'(exp_vcnt));
            chk({tag, "/stall_busy"}, 32'(stall_ok), 32'd1);
            chk({tag, "/stall_done"}, 32'(stall), 32'd0);
            chk({tag, "/valid_done"}, 32'(bus_if.bus_valid), 32'd0);
            chk({tag, "/bus_err"},   32'(bus_err), 32'(got.err));
            chk({tag, "/misalign"},  32'(misalign), 32'(got.mis));
            chk({tag, "/rdata_raw"}, rdata_raw, got.rdata);
            chk({tag, "/word_sel"},  32'(word_sel), 32'(got.wsel));
        end
        mem_req = 1'b0;
        tick();
        chk({tag, "/done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        cpu_rstn = 1'b1;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
        m_rdata = 32'h0; m_wsel = 2'b00;
        #3 cpu_rstn = 1'b0;
        tick(); tick();

        chk("rst/stall",     32'(stall), 32'd0);
        chk("rst/done",      32'(done), 32'd0);
        chk("rst/bus_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("rst/bus_we",    32'(bus_if.bus_we), 32'd0);
        chk("rst/bus_wstrb", 32'(bus_if.bus_wstrb), 32'd0);
        chk("rst/bus_addr",  bus_if.bus_addr, 32'h0);
        chk("rst/bus_wdata", bus_if.bus_wdata, 32'h0);
        chk("rst/rdata_raw", rdata_raw, 32'h0);
        chk("rst/word_sel",  32'(word_sel), 32'd0);
        chk("rst/bus_err",   32'(bus_err), 32'd0);
        chk("rst/misalign",  32'(misalign), 32'd0);
        cpu_rstn = 1'b1;
        tick();

        access("st_byte",    1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);
        access("ld_half",    1'b0, 2'b01, 32'h0000_2002, 32'h0,         0, 4, 32'hBEEF_1234);
        access("ld_timeout", 1'b0, 2'b10, 32'h0000_2401, 32'h0,         1000, 0, 32'h5555_AAAA);
        access("ld_mis_word",1'b0, 2'b10, 32'h0000_3001, 32'h0,         1, 1, 32'h1122_3344);
        access("st_half",    1'b1, 2'b01, 32'h0000_0006, 32'h0000_CAFE, 2, 0, 32'h0);
        access("st_mis_half",1'b1, 2'b01, 32'h0000_0007, 32'h0000_BEEF, 0, 0, 32'h0);
        access("st_word",    1'b1, 2'b11, 32'h0000_0010, 32'h1234_5678, 0, 0, 32'h0);
        access("ld_byte",    1'b0, 2'b00, 32'h0000_0021, 32'h0,         0, 2, 32'hA1B2_C3D4);

        // Stray rvalid outside a transaction must not disturb the load registers
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hFFFF_0000;
        tick(); tick();
        bus_if.bus_rvalid = 1'b0;
        chk("idle_rvalid/rdata_raw", rdata_raw, m_rdata);
        chk("idle_rvalid/done",      32'(done), 32'd0);

        // Reset while bus_valid is high drops it without a clock edge
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h0000_0500;
        tick();
        chk("rst_req/valid_before", 32'(bus_if.bus_valid), 32'd1);
        #2 cpu_rstn = 1'b0;
        #1;
        chk("rst_req/valid_after", 32'(bus_if.bus_valid), 32'd0);
        chk("rst_req/rdata_raw",   rdata_raw, 32'h0);
        m_rdata = 32'h0; m_wsel = 2'b00;
        mem_req = 1'b0;
        #1;
        chk("rst_req/stall_idle", 32'(stall), 32'd0);
        tick();
        cpu_rstn = 1'b1;
        tick();

        // Reset while waiting for read data
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h0000_4000;
        tick();
        bus_if.bus_ready = 1'b1;
        tick();
        bus_if.bus_ready = 1'b0;
        chk("rst_wait/stall_wait", 32'(stall), 32'd1);
        chk("rst_wait/valid_wait", 32'(bus_if.bus_valid), 32'd0);
        mem_req = 1'b0;
        #2 cpu_rstn = 1'b0;
        #1;
        chk("rst_wait/stall_after", 32'(stall), 32'd0);
        chk("rst_wait/valid_after", 32'(bus_if.bus_valid), 32'd0);
        chk("rst_wait/done_after",  32'(done), 32'd0);
        tick();
        cpu_rstn = 1'b1;
        tick();
        access("ld_after_rst", 1'b0, 2'b10, 32'h0000_4004, 32'h0, 0, 1, 32'h0BAD_F00D);

        // Back-to-back loads using the same-cycle ready/rvalid shortcut
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = 2'(i % 3);
            ad = 32'h0000_5000 + 32'(i * 8) + ((sz == 2'b00) ? 32'd3 : ((sz == 2'b01) ? 32'd2 : 32'd0));
            access("ld_b2b", 1'b0, sz, ad, 32'h0, 0, 0, $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
